// File: rtl/mem_bridge.sv
// CPU-to-bus memory bridge: posted write buffer in front of a single-outstanding
// external bus, with loads held back until every buffered store has drained.
module mem_bridge #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read_enable,
    input  logic [31:0] read_address,
    output logic [31:0] read_data,
    input  logic        write_enable,
    input  logic [31:0] write_address,
    input  logic [3:0]  write_select,
    input  logic [31:0] write_data,
    output logic        stall_request,
    output logic        mem_request,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_select,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ack,
    output logic [1:0]  dbg_state_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [31:0]   WORD_MASK  = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic          done_q;
    logic [31:0]   read_data_q;
    logic          mem_request_q;
    logic          mem_write_q;
    logic [31:0]   mem_address_q;
    logic [3:0]    mem_select_q;
    logic [31:0]   mem_write_data_q;

    logic [31:0]   buf_addr_q [DEPTH];
    logic [3:0]    buf_sel_q  [DEPTH];
    logic [31:0]   buf_data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic full;
    logic enq;
    logic pop;

    // A full buffer refuses the store even if the head pops this same edge.
    assign full          = (count_q == FULL_COUNT);
    assign enq           = write_enable & ~full;
    assign pop           = (state_q == WRITE) & mem_ack;
    assign stall_request = (read_enable & ~done_q) | (write_enable & full);

    assign read_data      = read_data_q;
    assign mem_request    = mem_request_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = mem_address_q;
    assign mem_select     = mem_select_q;
    assign mem_write_data = mem_write_data_q;
    assign dbg_state_o    = state_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) tail_d = tail_q + 1'b1;
        if (pop) head_d = head_q + 1'b1;
        case ({enq, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            buf_addr_q[tail_q] <= write_address & WORD_MASK;
            buf_sel_q[tail_q]  <= write_select;
            buf_data_q[tail_q] <= write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            done_q           <= 1'b0;
            read_data_q      <= '0;
            mem_request_q    <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_select_q     <= '0;
            mem_write_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Stores drain first; a load waits while a store is still being offered.
                    if (count_q != '0) begin
                        state_q          <= WRITE;
                        mem_request_q    <= 1'b1;
                        mem_write_q      <= 1'b1;
                        mem_address_q    <= buf_addr_q[head_q];
                        mem_select_q     <= buf_sel_q[head_q];
                        mem_write_data_q <= buf_data_q[head_q];
                    end else if (read_enable & ~done_q & ~write_enable) begin
                        state_q       <= READ;
                        mem_request_q <= 1'b1;
                        mem_write_q   <= 1'b0;
                        mem_address_q <= read_address & WORD_MASK;
                        mem_select_q  <= 4'b1111;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state_q       <= IDLE;
                        mem_request_q <= 1'b0;
                        mem_write_q   <= 1'b0;
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        state_q       <= DONE;
                        mem_request_q <= 1'b0;
                        read_data_q   <= mem_read_data;
                        done_q        <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Bench for mem_bridge: a CPU-view memory and a bus-side memory are kept separately;
// the bus must deliver stores in order and loads must see every earlier store.
module tb_mem_bridge;

    localparam int DEPTH = 4;
    localparam int TMO   = 400;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        read_enable = 1'b0;
    logic [31:0] read_address = '0;
    logic [31:0] read_data;
    logic        write_enable = 1'b0;
    logic [31:0] write_address = '0;
    logic [3:0]  write_select = '0;
    logic [31:0] write_data = '0;
    logic        stall_request;
    logic        mem_request;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_select;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data = '0;
    logic        mem_ack = 1'b0;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;

    mem_bridge #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .read_enable    (read_enable),
        .read_address   (read_address),
        .read_data      (read_data),
        .write_enable   (write_enable),
        .write_address  (write_address),
        .write_select   (write_select),
        .write_data     (write_data),
        .stall_request  (stall_request),
        .mem_request    (mem_request),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_select     (mem_select),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_ack        (mem_ack),
        .dbg_state_o    (dbg_state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [29:0] w;
        logic [3:0]  s;
        logic [31:0] d;
    } st_t;

    st_t         sq[$];
    logic [31:0] bus_mem [logic [29:0]];
    logic [31:0] cpu_mem [logic [29:0]];

    logic        in_txn = 1'b0;
    logic        done_m = 1'b0;
    logic        prev_ack = 1'b0;
    logic        txn_wr = 1'b0;
    logic [31:0] txn_addr = '0;
    logic [31:0] txn_data = '0;
    logic [3:0]  txn_sel = '0;
    logic [31:0] model_rd = '0;
    logic [29:0] load_w = '0;
    logic [31:0] last_req_addr = '0;
    int          wait_cnt = 0;
    int          wait_target = 0;

    int          ack_delay = -1;
    logic        ack_block = 1'b0;
    logic        late_ack = 1'b0;

    function automatic logic [31:0] init_word(logic [29:0] w);
        return {~w[15:0], w[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] bus_rd(logic [29:0] w);
        return bus_mem.exists(w) ? bus_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] cpu_rd(logic [29:0] w);
        return cpu_mem.exists(w) ? cpu_mem[w] : init_word(w);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, bus responder and per-cycle compare, all at the falling edge.
    always @(negedge clock) begin
        logic full_m;
        logic ack_now;
        logic done_next;
        st_t  ent;
        if (reset) begin
            sq.delete();
            cpu_mem.delete();
            foreach (bus_mem[k]) cpu_mem[k] = bus_mem[k];
            in_txn        = 1'b0;
            done_m        = 1'b0;
            prev_ack      = 1'b0;
            model_rd      = '0;
            wait_cnt      = 0;
            mem_ack       = late_ack;
            mem_read_data = '0;
        end else begin
            full_m = (sq.size() == DEPTH);
            check("stall", {31'b0, stall_request},
                  {31'b0, (write_enable && full_m) || (read_enable && !done_m)});
            check("read_data", read_data, model_rd);
            if (prev_ack) check("idle_gap", {31'b0, mem_request}, 32'd0);

            if (in_txn) begin
                check("req_held", {31'b0, mem_request}, 32'd1);
                check("hold_write", {31'b0, mem_write}, {31'b0, txn_wr});
                check("hold_addr", mem_address, txn_addr);
                check("hold_sel", {28'b0, mem_select}, {28'b0, txn_sel});
                if (txn_wr) check("hold_data", mem_write_data, txn_data);
            end else if (mem_request) begin
                in_txn        = 1'b1;
                txn_wr        = mem_write;
                txn_addr      = mem_address;
                txn_sel       = mem_select;
                txn_data      = mem_write_data;
                last_req_addr = mem_address;
                wait_cnt      = 0;
                wait_target   = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
                if (sq.size() > 0) begin
                    check("txn_is_write", {31'b0, mem_write}, 32'd1);
                    check("wr_addr", mem_address, {sq[0].w, 2'b00});
                    check("wr_sel", {28'b0, mem_select}, {28'b0, sq[0].s});
                    check("wr_data", mem_write_data, sq[0].d);
                end else begin
                    check("rd_pending", {31'b0, read_enable}, 32'd1);
                    check("txn_is_read", {31'b0, mem_write}, 32'd0);
                    check("rd_addr", mem_address, {read_address[31:2], 2'b00});
                    check("rd_sel", {28'b0, mem_select}, 32'hF);
                    load_w = read_address[31:2];
                end
            end

            ack_now = 1'b0;
            if (in_txn) begin
                if (!ack_block && wait_cnt >= wait_target) ack_now = 1'b1;
                else wait_cnt++;
            end
            mem_ack       = ack_now | late_ack;
            mem_read_data = (in_txn && !txn_wr) ? bus_rd(txn_addr[31:2]) : 32'h0;

            done_next = 1'b0;
            if (ack_now) begin
                if (txn_wr) begin
                    bus_mem[txn_addr[31:2]] = merge(bus_rd(txn_addr[31:2]), txn_data, txn_sel);
                    if (sq.size() > 0) void'(sq.pop_front());
                end else begin
                    model_rd  = cpu_rd(load_w);
                    done_next = 1'b1;
                end
                in_txn = 1'b0;
            end
            prev_ack = ack_now;

            if (write_enable && !full_m) begin
                ent.w = write_address[31:2];
                ent.s = write_select;
                ent.d = write_data;
                sq.push_back(ent);
                cpu_mem[ent.w] = merge(cpu_rd(ent.w), write_data, write_select);
            end
            done_m = done_next;
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                            output int sc);
        logic ok;
        ok = 1'b0;
        sc = 0;
        write_enable  = 1'b1;
        write_address = a;
        write_select  = s;
        write_data    = d;
        for (int i = 0; i < TMO && !ok; i++) begin
            @(negedge clock);
            if (!stall_request) ok = 1'b1;
            else sc++;
        end
        check("store_accepted", {31'b0, ok}, 32'd1);
        @(posedge clock);
        #1 write_enable = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, output int sc, output logic [31:0] rd);
        logic ok;
        ok = 1'b0;
        sc = 0;
        read_enable  = 1'b1;
        read_address = a;
        for (int i = 0; i < TMO && !ok; i++) begin
            @(negedge clock);
            if (!stall_request) ok = 1'b1;
            else sc++;
        end
        rd = read_data;
        check("load_done", {31'b0, ok}, 32'd1);
        @(posedge clock);
        #1 read_enable = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < TMO && !ok; i++) begin
            @(negedge clock);
            if (sq.size() == 0 && !in_txn && !mem_request) ok = 1'b1;
        end
        check("drain_done", {31'b0, ok}, 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < TMO && !ok; i++) begin
            @(negedge clock);
            if (mem_request) ok = 1'b1;
        end
        check("request_seen", {31'b0, ok}, 32'd1);
    endtask

    initial begin
        int          sc;
        logic [31:0] rd;
        int          op;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_mem_request", {31'b0, mem_request}, 32'd0);
        check("rst_mem_write", {31'b0, mem_write}, 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_select", {28'b0, mem_select}, 32'd0);
        check("rst_mem_write_data", mem_write_data, 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_stall", {31'b0, stall_request}, 32'd0);
        check("rst_state", {30'b0, dbg_state}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Single store, ack two cycles after the request.
        ack_delay = 2;
        do_store(32'h100, 4'hF, 32'h1122_3344, sc);
        check("t035_stall", sc, 0);
        wait_req();
        check("t035_write", {31'b0, mem_write}, 32'd1);
        check("t035_addr", mem_address, 32'h100);
        check("t035_data", mem_write_data, 32'h1122_3344);
        check("t035_sel", {28'b0, mem_select}, 32'hF);
        wait_idle();

        // Fill the buffer with the bus stalled; the fifth store waits for the first ack.
        ack_block = 1'b1;
        ack_delay = 0;
        for (int i = 0; i < 4; i++) begin
            do_store(32'h140 + 32'(i * 4), 4'hF, $urandom, sc);
            check("t036_no_stall", sc, 0);
        end
        write_enable  = 1'b1;
        write_address = 32'h150;
        write_select  = 4'b0110;
        write_data    = 32'hDEAD_BEEF;
        repeat (2) begin
            @(negedge clock);
            check("t036_full_stall", {31'b0, stall_request}, 32'd1);
        end
        @(posedge clock);
        #1 ack_block = 1'b0;
        @(negedge clock);
        check("t036_ack_cycle_req", {31'b0, mem_request}, 32'd1);
        check("t036_ack_cycle_stall", {31'b0, stall_request}, 32'd1);
        @(negedge clock);
        check("t036_release", {31'b0, stall_request}, 32'd0);
        @(posedge clock);
        #1 write_enable = 1'b0;
        wait_idle();

        // Store then immediate load of the same word.
        ack_delay = -1;
        do_store(32'h200, 4'hF, 32'hAABB_CCDD, sc);
        do_load(32'h200, sc, rd);
        check("t037_read_data", rd, 32'hAABB_CCDD);
        wait_idle();

        // Load with empty buffer and immediate ack.
        bus_mem[30'h81] = 32'hCAFE_F00D;
        cpu_mem[30'h81] = 32'hCAFE_F00D;
        ack_delay = 0;
        do_load(32'h207, sc, rd);
        check("t038_stall_cycles", sc, 2);
        check("t038_read_data", rd, 32'hCAFE_F00D);
        check("t038_addr", last_req_addr, 32'h204);
        wait_idle();

        // Reset in the middle of a buffered write; a late ack must be ignored.
        ack_block = 1'b1;
        for (int i = 0; i < 3; i++) do_store(32'h180 + 32'(i * 4), 4'hF, $urandom, sc);
        wait_req();
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        late_ack = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("t039_req_low", {31'b0, mem_request}, 32'd0);
            check("t039_stall", {31'b0, stall_request}, 32'd0);
        end
        @(posedge clock);
        #1 late_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_store(32'h1A0 + 32'(i * 4), 4'hF, $urandom, sc);
            check("t039_empty_after_reset", sc, 0);
        end
        ack_block = 1'b0;
        ack_delay = -1;
        wait_idle();

        // Store and load offered together: store goes first.
        write_enable  = 1'b1;
        write_address = 32'h1C0;
        write_select  = 4'hF;
        write_data    = 32'h1234_5678;
        read_enable   = 1'b1;
        read_address  = 32'h1C0;
        @(negedge clock);
        check("t040_stall", {31'b0, stall_request}, 32'd1);
        @(posedge clock);
        #1 write_enable = 1'b0;
        do_load(32'h1C0, sc, rd);
        check("t040_read_data", rd, 32'h1234_5678);
        wait_idle();

        // Randomized traffic over a small address window so loads hit recent stores.
        for (int n = 0; n < 250; n++) begin
            op = int'($urandom_range(0, 9));
            if (op < 5) begin
                do_store(32'h300 + 32'($urandom_range(0, 15) * 4), 4'($urandom_range(1, 15)),
                         $urandom, sc);
            end else if (op < 8) begin
                do_load(32'h300 + 32'($urandom_range(0, 63)), sc, rd);
            end else begin
                ack_block = (op == 9);
                repeat ($urandom_range(1, 4)) @(posedge clock);
                #1 ack_block = 1'b0;
            end
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter: DEPTH, default 4, meaning write-buffer entries (power of two, 2..16).
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 read_enable  input  1  CPU load request, held stable while stall_request is high.
REQ-005 read_address  input  32  CPU load byte address; word = bits [31:2].
REQ-006 read_data  output  32  load data, registered.
REQ-007 write_enable  input  1  CPU store request, held stable while stall_request is high.
REQ-008 write_address  input  32  CPU store byte address.
REQ-009 write_select  input  4  store byte lanes.
REQ-010 write_data  input  32  store data.
REQ-011 stall_request  output  1  combinational; high = CPU must hold its memory stage.
REQ-012 mem_request  output  1  external bus transaction valid.
REQ-013 mem_write  output  1  1 = write transaction, 0 = read.
REQ-014 mem_address  output  32  word-aligned bus address ({addr[31:2],2'b00}).
REQ-015 mem_select  output  4  byte lanes (4'b1111 for reads).
REQ-016 mem_write_data  output  32  bus write data.
REQ-017 mem_read_data  input  32  bus read data, valid when mem_ack high on a read.
REQ-018 mem_ack  input  1  bus completion; one transaction completes per ack cycle.

Function
REQ-019 Write buffer: FIFO of DEPTH entries {word address, select, data}; wrap-around pointers plus count.
REQ-020 Store accept: write_enable high and count<DEPTH -> entry enqueued at that edge; stall_request low for the store.
REQ-021 Store with buffer full -> stall_request high; no enqueue that cycle, even if a drain completes the same cycle (no full bypass).
REQ-022 FSM states IDLE, WRITE, READ, DONE.
REQ-023 IDLE: count>0 -> WRITE with head entry presented; else read_enable high and done flag low -> READ; else stay.
REQ-024 WRITE: mem_request=1, mem_write=1, address/select/data from head, all stable until mem_ack; on mem_ack pop head, -> IDLE.
REQ-025 READ: mem_request=1, mem_write=0, mem_select=4'b1111, address from read_address; on mem_ack latch mem_read_data into read_data, -> DONE.
REQ-026 DONE: one cycle; done flag high; -> IDLE; done flag cleared next cycle.
REQ-027 stall_request = (read_enable & ~done) | (write_enable & count==DEPTH); write takes priority if both enables high (read stalled until store accepted).
REQ-028 Loads always follow all buffered stores (buffer fully drained before READ), guaranteeing read-after-write ordering.
REQ-029 mem_request low in IDLE and DONE; at most one transaction outstanding; minimum one idle cycle between transactions.
REQ-030 Load latency with empty buffer and ack in first request cycle: stall high 2 cycles, low in 3rd cycle with read_data valid.
REQ-031 Simultaneous enqueue (not full) and pop: count unchanged, both take effect.
REQ-032 read_data holds its value until the next read completion.

Reset
REQ-033 reset high at an edge: state=IDLE, count=0, pointers=0, done=0, read_data=0, mem_request=0, mem_write=0, mem_address=0, mem_select=0, mem_write_data=0.
REQ-034 Reset mid-transaction abandons it: buffered stores discarded, a late mem_ack after reset ignored.

Verification
REQ-035 Store 0x11223344 sel 4'b1111 to 0x100, ack after 2 cycles -> no stall; bus write addr 0x100 data 0x11223344 sel 4'hF; count returns 0.
REQ-036 DEPTH=4, 5 back-to-back stores, mem_ack held low -> stall_request high on 5th; releases the cycle after first ack; 5th entry enqueued then.
REQ-037 Store 0xAABBCCDD to 0x200 then immediate load 0x200, bus memory model -> bus write issued before read; read_data=0xAABBCCDD.
REQ-038 Load 0x204 (byte address 0x207), empty buffer, immediate ack data 0xCAFEF00D -> mem_address=0x204, stall 2 cycles, read_data=0xCAFEF00D in 3rd cycle.
REQ-039 Reset asserted during WRITE with 3 entries -> next cycle count=0, mem_request=0; ack arriving afterwards changes nothing.
REQ-040 read_enable and write_enable both high, buffer not full -> store enqueued first cycle, read completes after store drains.
